// File: rtl/brnfck_ctrl_stack.sv
// brnfck_ctrl_stack
// Control unit for a Brainfuck interpreter. Fetches one ASCII instruction per
// cycle from combinational program memory, issues single-cycle datapath
// commands, keeps a loop-return stack and handles '[' forward skipping.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a run (tape clear, then execute from pc 0)
//   symbol[7:0]           instruction byte at pc
//   cell_zero             current tape cell is 0
//   in_valid / in_ack     input byte handshake
//   out_valid / out_ack   output byte handshake
//   pc[PC_W-1:0]          program counter
//   cell_inc, cell_dec, head_inc, head_dec, cell_load, cell_clear
//                         one-cycle datapath commands
//   ready                 idle, accepts start
//   error, err_code[1:0]  run aborted: 01 overflow, 10 unmatched ']',
//                         11 unmatched '['
//   stack_depth           live loop-stack entries
//   step                  (only with BRNFCK_STEP_EN) EXEC/SKIP advance enable
//
// Build option: define BRNFCK_STEP_EN to add the step input.
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | zeroing every tape cell, head walks once around the tape
// EXEC    | executing one instruction per cycle
// OUT     | presenting current cell until out_ack
// IN      | requesting input byte until in_valid
// SKIP    | scanning forward past a loop whose cell was zero
// ERROR   | run aborted, err_code held until start

module brnfck_ctrl_stack #(
  parameter int PC_W        = 8,
  parameter int HEAD_W      = 5,
  parameter int STACK_DEPTH = 8,
  parameter int NEST_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [7:0]                     symbol,
  input  logic                           cell_zero,
  input  logic                           in_valid,
  input  logic                           out_ack,
  output logic [PC_W-1:0]                pc,
  output logic                           cell_inc,
  output logic                           cell_dec,
  output logic                           head_inc,
  output logic                           head_dec,
  output logic                           cell_load,
  output logic                           cell_clear,
  output logic                           in_ack,
  output logic                           out_valid,
  output logic                           ready,
  output logic                           error,
  output logic [1:0]                     err_code,
  output logic [$clog2(STACK_DEPTH):0]   stack_depth
`ifdef BRNFCK_STEP_EN
  ,
  input  logic                           step
`endif
);

  localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_EXEC, S_OUT, S_IN, S_SKIP, S_ERROR
  } state_t;

  state_t            state, state_nx;
  logic [PC_W-1:0]   pc_nx, pc_inc;
  logic [SP_W-1:0]   sp, sp_nx;
  logic [NEST_W-1:0] nest, nest_nx;
  logic [HEAD_W-1:0] clr_cnt, clr_cnt_nx;
  logic [1:0]        err_q, err_nx;
  logic [PC_W-1:0]   stack_mem [STACK_DEPTH];
  logic [PC_W-1:0]   top;
  logic              push;
  logic              adv;

`ifdef BRNFCK_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  assign pc_inc = pc + 1'b1;
  assign top    = stack_mem[IDX_W'(sp - 1'b1)];

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    sp_nx      = sp;
    nest_nx    = nest;
    clr_cnt_nx = clr_cnt;
    err_nx     = err_q;
    push       = 1'b0;
    cell_inc   = 1'b0;
    cell_dec   = 1'b0;
    head_inc   = 1'b0;
    head_dec   = 1'b0;
    cell_load  = 1'b0;
    cell_clear = 1'b0;
    in_ack     = 1'b0;
    out_valid  = 1'b0;
    ready      = 1'b0;
    error      = 1'b0;

    case (state)
      S_IDLE, S_ERROR: begin
        ready = (state == S_IDLE);
        error = (state == S_ERROR);
        if (start) begin
          state_nx   = S_CLEAR;
          pc_nx      = '0;
          sp_nx      = '0;
          nest_nx    = '0;
          clr_cnt_nx = '0;
          err_nx     = 2'b00;
        end
      end
      S_CLEAR: begin
        cell_clear = 1'b1;
        head_inc   = 1'b1;
        clr_cnt_nx = clr_cnt + 1'b1;
        if (clr_cnt == '1) state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (adv) begin
          case (symbol)
            8'h2B: begin cell_inc = 1'b1; pc_nx = pc_inc; end
            8'h2D: begin cell_dec = 1'b1; pc_nx = pc_inc; end
            8'h3E: begin head_inc = 1'b1; pc_nx = pc_inc; end
            8'h3C: begin head_dec = 1'b1; pc_nx = pc_inc; end
            8'h2E: state_nx = S_OUT;
            8'h2C: state_nx = S_IN;
            8'h00: begin state_nx = S_IDLE; sp_nx = '0; end
            8'h5B: begin
              if (cell_zero) begin
                pc_nx    = pc_inc;
                nest_nx  = '0;
                state_nx = S_SKIP;
              end else if (sp == SP_W'(STACK_DEPTH)) begin
                state_nx = S_ERROR;
                err_nx   = 2'b01;
              end else begin
                push  = 1'b1;
                sp_nx = sp + 1'b1;
                pc_nx = pc_inc;
              end
            end
            8'h5D: begin
              if (sp == '0) begin
                state_nx = S_ERROR;
                err_nx   = 2'b10;
              end else if (!cell_zero) begin
                // jump back to the instruction after the matching '['
                pc_nx = top + 1'b1;
              end else begin
                sp_nx = sp - 1'b1;
                pc_nx = pc_inc;
              end
            end
            default: pc_nx = pc_inc;
          endcase
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ack) begin
          pc_nx    = pc_inc;
          state_nx = S_EXEC;
        end
      end
      S_IN: begin
        in_ack = 1'b1;
        if (in_valid) begin
          cell_load = 1'b1;
          pc_nx     = pc_inc;
          state_nx  = S_EXEC;
        end
      end
      S_SKIP: begin
        if (adv) begin
          case (symbol)
            8'h5B: begin
              if (nest == '1) begin
                state_nx = S_ERROR;
                err_nx   = 2'b11;
              end else begin
                nest_nx = nest + 1'b1;
                pc_nx   = pc_inc;
              end
            end
            8'h5D: begin
              pc_nx = pc_inc;
              if (nest == '0) state_nx = S_EXEC;
              else            nest_nx  = nest - 1'b1;
            end
            8'h00: begin
              state_nx = S_ERROR;
              err_nx   = 2'b11;
            end
            default: pc_nx = pc_inc;
          endcase
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // reset overrides outputs combinationally so the handshake drops at once
    if (rst) begin
      push       = 1'b0;
      cell_inc   = 1'b0;
      cell_dec   = 1'b0;
      head_inc   = 1'b0;
      head_dec   = 1'b0;
      cell_load  = 1'b0;
      cell_clear = 1'b0;
      in_ack     = 1'b0;
      out_valid  = 1'b0;
      ready      = 1'b1;
      error      = 1'b0;
    end
  end

  assign err_code    = rst ? 2'b00 : err_q;
  assign stack_depth = rst ? '0 : sp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      sp      <= '0;
      nest    <= '0;
      clr_cnt <= '0;
      err_q   <= 2'b00;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      sp      <= sp_nx;
      nest    <= nest_nx;
      clr_cnt <= clr_cnt_nx;
      err_q   <= err_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack_mem[IDX_W'(sp)] <= pc;
  end

endmodule

// File: tb/tb_brnfck_ctrl_stack.sv
module tb_brnfck_ctrl_stack;
  localparam int PC_W = 8, HEAD_W = 5, SD = 2, NEST_W = 2;
  localparam int SP_W = $clog2(SD) + 1;
  localparam int CELLS = 1 << HEAD_W;
  localparam int NEST_MAX = (1 << NEST_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, cell_zero = 1'b0, in_valid = 1'b0, out_ack = 1'b0;
  logic [7:0] symbol;
  logic [PC_W-1:0] pc;
  logic cell_inc, cell_dec, head_inc, head_dec, cell_load, cell_clear;
  logic in_ack, out_valid, ready, error;
  logic [1:0] err_code;
  logic [SP_W-1:0] stack_depth;

  logic [7:0] prog [256];
  logic [7:0] tape [CELLS];
  int head = 0;
  logic [7:0] in_byte = 8'h00;
  assign symbol = prog[pc];

  brnfck_ctrl_stack #(.PC_W(PC_W), .HEAD_W(HEAD_W), .STACK_DEPTH(SD), .NEST_W(NEST_W)) dut (
    .clk(clk), .rst(rst), .start(start), .symbol(symbol), .cell_zero(cell_zero),
    .in_valid(in_valid), .out_ack(out_ack), .pc(pc),
    .cell_inc(cell_inc), .cell_dec(cell_dec), .head_inc(head_inc), .head_dec(head_dec),
    .cell_load(cell_load), .cell_clear(cell_clear), .in_ack(in_ack), .out_valid(out_valid),
    .ready(ready), .error(error), .err_code(err_code), .stack_depth(stack_depth)
`ifdef BRNFCK_STEP_EN
    , .step(1'b1)
`endif
  );

  // behavioural reference: interpreter mode, queue stack, integer pc
  typedef enum {M_IDLE, M_CLEAR, M_EXEC, M_OUT, M_IN, M_SKIP, M_ERR} mode_t;
  mode_t m_mode = M_IDLE, n_mode;
  int m_pc, n_pc, m_nest, n_nest, m_clr, n_clr, m_err, n_err;
  int m_stk[$], n_stk[$];
  bit m_known = 0;
  logic e_ci, e_cd, e_hi, e_hd, e_ld, e_cl, e_ia, e_ov, e_rd, e_er;

  int checks = 0, errors = 0;
  int cz_q[$];
  int cnt_clear, cnt_inc, cnt_dec, max_sd;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int inc(int p);
    return (p + 1) % 256;
  endfunction

  task automatic begin_run();
    n_mode = M_CLEAR; n_pc = 0; n_stk = {}; n_nest = 0; n_clr = 0; n_err = 0;
  endtask

  task automatic go_err(int code);
    n_mode = M_ERR; n_err = code;
  endtask

  task automatic model_eval();
    logic [7:0] sym;
    sym = prog[m_pc];
    n_mode = m_mode; n_pc = m_pc; n_nest = m_nest; n_clr = m_clr; n_err = m_err; n_stk = m_stk;
    {e_ci, e_cd, e_hi, e_hd, e_ld, e_cl, e_ia, e_ov, e_rd, e_er} = '0;
    if (rst) begin
      e_rd = 1; n_mode = M_IDLE; n_pc = 0; n_stk = {}; n_nest = 0; n_clr = 0; n_err = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin e_rd = 1; if (start) begin_run(); end
        M_ERR:  begin e_er = 1; if (start) begin_run(); end
        M_CLEAR: begin
          e_cl = 1; e_hi = 1; n_clr = m_clr + 1;
          if (n_clr == CELLS) n_mode = M_EXEC;
        end
        M_EXEC: begin
          case (sym)
            8'h2B: begin e_ci = 1; n_pc = inc(m_pc); end
            8'h2D: begin e_cd = 1; n_pc = inc(m_pc); end
            8'h3E: begin e_hi = 1; n_pc = inc(m_pc); end
            8'h3C: begin e_hd = 1; n_pc = inc(m_pc); end
            8'h2E: n_mode = M_OUT;
            8'h2C: n_mode = M_IN;
            8'h00: begin n_mode = M_IDLE; n_stk = {}; end
            8'h5B: begin
              if (cell_zero) begin n_pc = inc(m_pc); n_nest = 0; n_mode = M_SKIP; end
              else if (m_stk.size() == SD) go_err(1);
              else begin n_stk.push_back(m_pc); n_pc = inc(m_pc); end
            end
            8'h5D: begin
              if (m_stk.size() == 0) go_err(2);
              else if (!cell_zero) n_pc = inc(m_stk[$]);
              else begin void'(n_stk.pop_back()); n_pc = inc(m_pc); end
            end
            default: n_pc = inc(m_pc);
          endcase
        end
        M_OUT: begin e_ov = 1; if (out_ack) begin n_pc = inc(m_pc); n_mode = M_EXEC; end end
        M_IN: begin
          e_ia = 1;
          if (in_valid) begin e_ld = 1; n_pc = inc(m_pc); n_mode = M_EXEC; end
        end
        M_SKIP: begin
          case (sym)
            8'h5B: if (m_nest == NEST_MAX) go_err(3);
                   else begin n_nest = m_nest + 1; n_pc = inc(m_pc); end
            8'h5D: begin
              n_pc = inc(m_pc);
              if (m_nest == 0) n_mode = M_EXEC; else n_nest = m_nest - 1;
            end
            8'h00: go_err(3);
            default: n_pc = inc(m_pc);
          endcase
        end
        default: ;
      endcase
    end
  endtask

  // one clock: inputs already set at posedge+1; compare at posedge+3
  task automatic cycle();
    logic s_ci, s_cd, s_hi, s_hd, s_ld, s_cl;
    logic [7:0] sym;
    sym = prog[m_pc];
    if (cz_q.size() > 0 && !rst && m_mode == M_EXEC && (sym == 8'h5B || sym == 8'h5D))
      cell_zero = (cz_q.pop_front() != 0);
    else
      cell_zero = (tape[head] == 8'h00);
    #2;
    model_eval();
    if (m_known) begin
      check("pc", pc, m_pc);
      check("outputs",
            {cell_inc, cell_dec, head_inc, head_dec, cell_load, cell_clear, in_ack, out_valid, ready, error},
            {e_ci, e_cd, e_hi, e_hd, e_ld, e_cl, e_ia, e_ov, e_rd, e_er});
      check("err_code", err_code, rst ? 0 : m_err);
      check("stack_depth", stack_depth, rst ? 0 : m_stk.size());
    end
    {s_ci, s_cd, s_hi, s_hd, s_ld, s_cl} = {cell_inc, cell_dec, head_inc, head_dec, cell_load, cell_clear};
    cnt_clear += int'(cell_clear);
    cnt_inc   += int'(cell_inc);
    cnt_dec   += int'(cell_dec);
    if (int'(stack_depth) > max_sd) max_sd = int'(stack_depth);
    @(posedge clk); #1;
    if (s_cl) tape[head] = 8'h00;
    if (s_ci) tape[head] = tape[head] + 8'h01;
    if (s_cd) tape[head] = tape[head] - 8'h01;
    if (s_ld) tape[head] = in_byte;
    if (s_hi) head = (head + 1) % CELLS;
    if (s_hd) head = (head + CELLS - 1) % CELLS;
    m_mode = n_mode; m_pc = n_pc; m_nest = n_nest; m_clr = n_clr; m_err = n_err; m_stk = n_stk;
    if (rst) m_known = 1;
  endtask

  task automatic load_prog(string s);
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) prog[i] = s[i];
  endtask

  task automatic do_reset();
    rst = 1; start = 0; in_valid = 0; out_ack = 0; cycle(); rst = 0;
  endtask

  task automatic do_start();
    start = 1; cycle(); start = 0;
    cnt_clear = 0; cnt_inc = 0; cnt_dec = 0; max_sd = 0;
  endtask

  task automatic run_done(int max);
    int k = 0;
    while (!(m_mode == M_IDLE || m_mode == M_ERR) && k < max) begin cycle(); k++; end
    check("run_terminates", ready | error, 1);
  endtask

  initial begin
    for (int i = 0; i < CELLS; i++) tape[i] = 8'h00;
    load_prog("");
    @(posedge clk); #1;

    // clear phase length, "++." with a late out_ack
    load_prog("++.");
    do_reset();
    do_start();
    for (int k = 0; k < 60 && m_mode != M_OUT; k++) cycle();
    check("clear_cycles", cnt_clear, CELLS);
    check("incs_before_out", cnt_inc, 2);
    check("out_pc", pc, 2);
    repeat (3) cycle();
    out_ack = 1; cycle(); out_ack = 0;
    check("pc_after_ack", pc, 3);
    cycle();
    check("idle_after_end", ready, 1);

    // skipped loop
    load_prog("[+]");
    do_start();
    run_done(80);
    check("skip_no_inc", cnt_inc, 0);
    check("skip_end_pc", pc, 3);

    // loop taken twice, then exits
    load_prog("+[-]");
    cz_q = {0, 0, 0, 1};
    do_start();
    run_done(80);
    check("loop_decs", cnt_dec, 3);
    check("loop_max_depth", max_sd, 1);
    check("loop_end_pc", pc, 4);

    // error cases
    load_prog("[[[");
    cz_q = {0, 0, 0};
    do_start();
    run_done(80);
    check("ovf_code", err_code, 1);
    check("ovf_pc", pc, 2);
    check("ovf_error", error, 1);
    load_prog("]");
    cz_q = {};
    do_start();
    run_done(80);
    check("unmatched_close", err_code, 2);
    load_prog("[[]");
    cz_q = {1};
    do_start();
    run_done(80);
    check("unmatched_open", err_code, 3);
    load_prog("[[[[[");
    cz_q = {1};
    do_start();
    run_done(80);
    check("nest_saturate", err_code, 3);
    check("nest_saturate_pc", pc, 4);
    cz_q = {};

    // reset mid-handshake
    load_prog(".");
    do_start();
    for (int k = 0; k < 60 && m_mode != M_OUT; k++) cycle();
    cycle();
    rst = 1; cycle(); rst = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_ready", ready, 1);
    check("rst_pc", pc, 0);
    check("rst_depth", stack_depth, 0);

    // pc wraps through a program with no terminator
    for (int i = 0; i < 256; i++) prog[i] = 8'h61;
    do_start();
    repeat (CELLS + 300) cycle();
    do_reset();

    // randomized programs and handshakes
    for (int r = 0; r < 25; r++) begin
      logic [7:0] alpha [10];
      int len;
      alpha = '{8'h2B, 8'h2D, 8'h3E, 8'h3C, 8'h5B, 8'h5D, 8'h2E, 8'h2C, 8'h61, 8'h00};
      len = $urandom_range(1, 24);
      for (int i = 0; i < 256; i++) prog[i] = 8'h00;
      for (int i = 0; i < len; i++) prog[i] = alpha[$urandom_range(0, 9)];
      do_reset();
      for (int k = 0; k < 300; k++) begin
        start    = ($urandom_range(0, 3) == 0);
        in_valid = ($urandom_range(0, 2) == 0);
        out_ack  = ($urandom_range(0, 2) == 0);
        rst      = ($urandom_range(0, 149) == 0);
        in_byte  = 8'($urandom);
        cycle();
      end
      rst = 0; start = 0; in_valid = 0; out_ack = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
